ahb_master_arbiter: RTL
=======================

# ahb_master_arbiter

Shares the single AHB-Lite memory port among the three bus masters of the pipelined LEG core: I$ refill, D$ refill/writeback, and the MMU translation-walk hardware. It holds a registered address-phase grant and a separately tracked data-phase owner, so back-to-back transfers from one master pipeline without bubbles. Ownership changes only at clean transfer boundaries. Fixed priority (MMU > D$ > I$) is overridden by a per-master starvation counter.

## Interface
Parameters:
- NREQ, 3, number of masters; index 0 = I$, 1 = D$, 2 = MMU walk
- STARVE_LIMIT, 16, wait cycles after which a requesting master is forced to win the next arbitration
- WAITW, 5, width of each wait counter; must satisfy 2^WAITW > STARVE_LIMIT

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_i  in  NREQ  per-master bus request; held high until the master's last address phase is accepted
- haddr_i  in  NREQ×32  per-master HADDR
- htrans_i  in  NREQ×2  per-master HTRANS
- hwrite_i  in  NREQ  per-master HWRITE
- hsize_i  in  NREQ×3  per-master HSIZE
- hwdata_i  in  NREQ×32  per-master HWDATA
- HREADY  in  1  slave ready
- HADDR  out  32  muxed address
- HTRANS  out  2  muxed transfer type
- HWRITE  out  1  muxed write
- HSIZE  out  3  muxed size
- HWDATA  out  32  write data, muxed by data-phase owner
- gnt_o  out  NREQ  one-hot address-phase grant
- dready_o  out  NREQ  one-hot data-phase completion strobe, HREADY routed to data owner
- busy_o  out  1  any grant or data phase outstanding

## Operation
- Registers: grant (one-hot or zero), downer (one-hot or zero), wait counters wcnt[NREQ].
- States: IDLE (grant = 0), OWNED (grant ≠ 0).
- Arbitration point: rising edge with HREADY = 1 and either IDLE, or owner's req_i = 0. The owner's HTRANS = IDLE with req_i still high does not release the bus.
- Winner: highest-index master among those with req_i = 1 and wcnt ≥ STARVE_LIMIT; if none starved, highest-index requester (MMU > D$ > I$). If nobody requests, go to IDLE.
- A master may be re-granted immediately at its own release point if it is still the winner.
- Address mux driven from grant; with grant = 0, HTRANS = IDLE(00), HADDR = 0, HWRITE = 0, HSIZE = 0.
- Data owner: on each edge with HREADY = 1, downer ← grant if HTRANS was NONSEQ or SEQ, else 0. HWDATA is muxed by downer and is 0 when downer = 0.
- dready_o[i] = HREADY & downer[i], combinational.
- Wait counters:
  - wcnt[i] increments, saturating at 2^WAITW−1, each cycle req_i[i] = 1 and gnt_o[i] = 0.
  - wcnt[i] clears when the master is granted or its req_i is low.
- busy_o = |grant | |downer.

## Timing
- Reset: grant = 0, downer = 0, all wcnt = 0.
  - Outputs during and after reset: HTRANS = 00, HADDR/HWDATA = 0, HWRITE = 0, HSIZE = 0, gnt_o = 0, dready_o = 0, busy_o = 0.
- Reset has priority over any in-flight transfer. Masters are reset on the same edge, so no drain is performed.
- Latency:
  - req_i rising in IDLE with HREADY = 1 → gnt_o at the next edge.
  - First address phase occupies that cycle.
  - dready_o follows one cycle later if the slave is zero-wait.
- While HREADY = 0, grant, downer and the bus outputs hold. Wait counters still advance.
- Handoff: old master's final data phase and new master's first address phase overlap in the same cycle (downer = old, grant = new). No idle cycle is inserted.
- Simultaneous starvation of I$ and D$: D$ wins. I$ keeps counting and wins at the next arbitration point.

## Structure
- Package leg_ahb_pkg holds:
  - htrans_t enum: IDLE = 00, BUSY = 01, NONSEQ = 10, SEQ = 11
  - hsize constants
  - requester index constants REQ_I = 0, REQ_D = 1, REQ_MMU = 2
- One sub-module, arb_wait_counter: per-master saturating counter with a starved flag, instantiated NREQ times.

## Test plan
- Reset mid-burst: D$ owns the bus with downer = D$; assert reset → next edge gnt_o = 000, HTRANS = 00, busy_o = 0.
- Priority: all three req_i rise together in IDLE → gnt_o = 100. Release MMU → 010. Release D$ → 001.
- Pipelined handoff: D$ issues 4-beat SEQ and drops req on the last beat while I$ requests → next edge gnt_o = 001 and dready_o = 010 in the same cycle, HWDATA = D$ data.
- Wait state: HREADY = 0 for 3 cycles during an MMU read → HADDR and gnt_o stable, dready_o = 000, then dready_o = 100 on the HREADY = 1 cycle.
- Starvation: D$ re-requests continuously while I$ waits. After 16 waiting cycles, I$ is granted at the next arbitration point even though D$ is requesting. wcnt[0] clears.
- Idle-hold: MMU is granted, drives HTRANS = IDLE with req high for 5 cycles while D$ requests → gnt_o stays 100.

Source files
------------

// File: rtl/leg_ahb_pkg.sv
// Shared AHB-Lite definitions for the LEG core memory port.
// Covers transfer types, transfer sizes and the bus-master indices.
package leg_ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HALF  = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    localparam int unsigned REQ_I   = 0;
    localparam int unsigned REQ_D   = 1;
    localparam int unsigned REQ_MMU = 2;

    // True for transfers that open a data phase.
    function automatic logic is_active(logic [1:0] t);
        return (t == NONSEQ) || (t == SEQ);
    endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// Per-master wait counter. It saturates at its maximum value and
// flags starvation once the count reaches STARVE_LIMIT.
module arb_wait_counter #(
    parameter int unsigned WAITW        = 5,
    parameter int unsigned STARVE_LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic req_i,
    input  logic gnt_i,
    output logic starved_o
);

    logic [WAITW-1:0] count_q, count_d;

    always_comb begin
        count_d = '0;
        if (req_i && !gnt_i) begin
            count_d = (&count_q) ? count_q : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign starved_o = {{(32 - WAITW){1'b0}}, count_q} >= STARVE_LIMIT;

endmodule

// File: rtl/ahb_master_arbiter.sv
// AHB-Lite arbiter for the three LEG bus masters, with fixed priority MMU > D$ > I$.
// Starvation overrides priority. The address-phase grant and the data-phase owner are tracked separately.
module ahb_master_arbiter
    import leg_ahb_pkg::*;
#(
    parameter int unsigned NREQ         = 3,
    parameter int unsigned STARVE_LIMIT = 16,
    parameter int unsigned WAITW        = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_i,
    input  logic [NREQ*32-1:0] haddr_i,
    input  logic [NREQ*2-1:0] htrans_i,
    input  logic [NREQ-1:0]   hwrite_i,
    input  logic [NREQ*3-1:0] hsize_i,
    input  logic [NREQ*32-1:0] hwdata_i,
    input  logic              HREADY,
    output logic [31:0]       HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [31:0]       HWDATA,
    output logic [NREQ-1:0]   gnt_o,
    output logic [NREQ-1:0]   dready_o,
    output logic              busy_o
);

    typedef enum logic {StIdle, StOwned} state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] downer_q, downer_d;
    logic [NREQ-1:0] starved, pool, winner;
    logic            arb_point;

    for (genvar i = 0; i < NREQ; i++) begin : g_wcnt
        arb_wait_counter #(
            .WAITW       (WAITW),
            .STARVE_LIMIT(STARVE_LIMIT)
        ) u_wcnt (
            .clk      (clk),
            .reset    (reset),
            .req_i    (req_i[i]),
            .gnt_i    (grant_q[i]),
            .starved_o(starved[i])
        );
    end

    // Starved requesters form the candidate pool whenever any exist; highest index wins.
    always_comb begin
        pool   = (|(starved & req_i)) ? (starved & req_i) : req_i;
        winner = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pool[i]) begin
                winner    = '0;
                winner[i] = 1'b1;
            end
        end
    end

    // HTRANS=IDLE with req held high keeps ownership; only dropping req releases the bus.
    assign arb_point = HREADY && ((state_q == StIdle) || ((grant_q & req_i) == '0));

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        downer_d = downer_q;
        if (arb_point) begin
            grant_d = winner;
            state_d = (winner != '0) ? StOwned : StIdle;
        end
        if (HREADY) begin
            downer_d = is_active(HTRANS) ? grant_q : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            downer_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            downer_q <= downer_d;
        end
    end

    always_comb begin
        HADDR  = '0;
        HTRANS = IDLE;
        HWRITE = 1'b0;
        HSIZE  = '0;
        HWDATA = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                HADDR  = haddr_i[i*32 +: 32];
                HTRANS = htrans_i[i*2 +: 2];
                HWRITE = hwrite_i[i];
                HSIZE  = hsize_i[i*3 +: 3];
            end
            if (downer_q[i]) begin
                HWDATA = hwdata_i[i*32 +: 32];
            end
        end
    end

    assign gnt_o    = grant_q;
    assign dready_o = {NREQ{HREADY}} & downer_q;
    assign busy_o   = (|grant_q) | (|downer_q);

endmodule
